// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready/data handshake bundle for one side of a pipeline stage.
//
// Signals:
//   valid  producer holds a live beat
//   ready  consumer can accept a beat this cycle
//   data   payload, DATA_W bits
//
// Modports:
//   master  producer side (drives valid/data, samples ready)
//   slave   consumer side (samples valid/data, drives ready)
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 128
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with a 2-entry skid buffer.
//
// The payload is opaque (instruction, PCs, operands, control bundle concatenated by the
// instantiating stage). in_ready is registered, so a downstream stall never forms a
// combinational path back upstream. flush turns both entries into bubbles (NOP_VALUE).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, synchronous release
//   flush       synchronous flush, discards held entries and any beat offered this cycle
//   in_if       upstream handshake (slave): valid/data in, ready out (registered)
//   out_if      downstream handshake (master): valid/data out, ready in
//   occupancy   number of held entries (0..2)
//   stall_cnt   cycles with out_valid=1 & out_ready=0 (saturating)
//   bubble_cnt  cycles with out_valid=0 & out_ready=1 (saturating)
//
// Build option: define STAGE_PERF_CNT_EN to include the performance counters; without it
// stall_cnt and bubble_cnt are tied to zero.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W    = 128,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_skid_if.slave     in_if,
    pipe_stage_skid_if.master    out_if,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    // Main slot M drives the outputs; skid slot S catches one beat while M is blocked.
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic              in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_if.valid & in_ready_q;
    assign out_fire = m_valid_q & out_if.ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;

        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = NOP_VALUE;
            s_valid_d = 1'b0;
            s_data_d  = NOP_VALUE;
        end else if (!m_valid_q) begin
            // Empty
            if (in_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = in_if.data;
            end
        end else if (!s_valid_q) begin
            // One entry
            if (in_fire && out_fire) begin
                m_data_d = in_if.data;
            end else if (in_fire) begin
                s_valid_d = 1'b1;
                s_data_d  = in_if.data;
            end else if (out_fire) begin
                m_valid_d = 1'b0;
                m_data_d  = NOP_VALUE;
            end
        end else if (out_fire) begin
            // Full: in_ready is low, so only the drain can happen
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
            s_data_d  = NOP_VALUE;
        end

        // Registered ready reflects whether the skid slot is free after this edge
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_q  <= 1'b0;
            m_data_q   <= NOP_VALUE;
            s_valid_q  <= 1'b0;
            s_data_q   <= NOP_VALUE;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = m_valid_q;
    assign out_if.data  = m_valid_q ? m_data_q : NOP_VALUE;
    // S is only ever valid alongside M, so the count never sees {M=0,S=1}
    assign occupancy    = {s_valid_q, m_valid_q & ~s_valid_q};

`ifdef STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    // Counters ignore flush; only reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (m_valid_q && !out_if.ready && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (!m_valid_q && out_if.ready && !(&bubble_cnt_q)) begin
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the stage.
module tb_pipe_stage_skid;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_stage_skid_if #(.DATA_W(DATA_W)) in_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W)) out_if ();

    pipe_stage_skid #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_if      (in_if),
        .out_if     (out_if),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of at most two beats
    logic [DATA_W-1:0] q[$];
    int unsigned       stall_m;
    int unsigned       bubble_m;

    int vectors;
    int miscompares;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : '0;
        check({tag, ".out_valid"}, 64'(out_if.valid), 64'(q.size() != 0));
        check({tag, ".out_data"}, 64'(out_if.data), 64'(exp_data));
        check({tag, ".occupancy"}, 64'(occupancy), 64'(q.size()));
        check({tag, ".in_ready"}, 64'(in_if.ready), 64'(q.size() < 2));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(stall_m));
        check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(bubble_m));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check outputs.
    task automatic step(input string tag, input logic iv, input logic [DATA_W-1:0] id,
                        input logic ordy, input logic fl);
        logic mv, in_fire, out_fire;
        in_if.valid  = iv;
        in_if.data   = id;
        out_if.ready = ordy;
        flush        = fl;
        mv       = (q.size() != 0);
        in_fire  = iv && (q.size() < 2);
        out_fire = mv && ordy;
`ifdef STAGE_PERF_CNT_EN
        if (mv && !ordy && stall_m < CNT_MAX) stall_m++;
        if (!mv && ordy && bubble_m < CNT_MAX) bubble_m++;
`endif
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(id);
        end
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        stall_m  = 0;
        bubble_m = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        flush        = 1'b0;

        // Reset state
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset");

        // Streaming 1,2,3... with out_ready high: one cycle latency, occupancy stays 1
        for (int i = 1; i <= 6; i++) begin
            step("stream", 1'b1, DATA_W'(i), 1'b1, 1'b0);
            check("stream_data", 64'(out_if.data), 64'(i));
        end
        step("stream_drain", 1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A then B with out_ready low fills the skid slot
        step("fill_a", 1'b1, 32'h0000_00a0, 1'b0, 1'b0);
        step("fill_b", 1'b1, 32'h0000_00b0, 1'b0, 1'b0);
        check("full_occ", 64'(occupancy), 64'd2);
        check("full_ready", 64'(in_if.ready), 64'd0);
        check("full_head", 64'(out_if.data), 64'h00a0);
        // Changing in_data while blocked must not disturb anything
        step("blocked", 1'b1, 32'hdead_beef, 1'b0, 1'b0);
        step("drain_a", 1'b0, '0, 1'b1, 1'b0);
        check("drain_a_data", 64'(out_if.data), 64'h00b0);
        check("drain_a_ready", 64'(in_if.ready), 64'd1);
        step("drain_b", 1'b0, '0, 1'b1, 1'b0);
        check("drain_b_valid", 64'(out_if.valid), 64'd0);

        // Flush while FULL with C offered the same cycle
        step("ffill_a", 1'b1, 32'h0000_00a1, 1'b0, 1'b0);
        step("ffill_b", 1'b1, 32'h0000_00b1, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h0000_00c1, 1'b0, 1'b1);
        check("flush_valid", 64'(out_if.valid), 64'd0);
        check("flush_data", 64'(out_if.data), 64'd0);
        check("flush_occ", 64'(occupancy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step("post_flush", 1'b0, '0, 1'b1, 1'b0);
            check("no_c", 64'(out_if.valid), 64'd0);
        end

        // Asynchronous reset mid-cycle while FULL
        step("rfill_a", 1'b1, 32'h0000_00a2, 1'b0, 1'b0);
        step("rfill_b", 1'b1, 32'h0000_00b2, 1'b0, 1'b0);
        in_if.valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("async_release");

`ifdef STAGE_PERF_CNT_EN
        // Stall counter saturation, survives flush, cleared by reset
        step("sat_load", 1'b1, 32'h0000_0055, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("sat", 1'b0, '0, 1'b0, 1'b0);
        check("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
        step("sat_flush", 1'b0, '0, 1'b0, 1'b1);
        check("stall_after_flush", 64'(stall_cnt), 64'(CNT_MAX));
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("stall_reset", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
`endif

        // Random traffic at 50% density, with occasional flushes
        for (int i = 0; i < 10000; i++) begin
            step("random", 1'($urandom_range(0, 1)), DATA_W'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 127) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
